arbitro_fifos: RTL and testbench
================================

ARBITRO_FIFOS -- requirements
Module: arbitro_fifos

Interface
REQ-001 The block SHALL take one clock and an asynchronous, active-low reset, named as below.
REQ-002 Parameter SHALL be: DATA_WIDTH, 8, lane/output data width.
REQ-003 Parameter SHALL be: FIFO_DEPTH, 4, entries per lane FIFO; power of two, at least 2.
REQ-004 Port SHALL be: clk  input  1  rising-edge clock.
REQ-005 Port SHALL be: reset_L  input  1  async active-low reset.
REQ-006 Port SHALL be: data_in0..data_in3  input  DATA_WIDTH each  lane data from the recirculation stage.
REQ-007 Port SHALL be: valid_in0..valid_in3  input  1 each  lane data qualifier.
REQ-008 Port SHALL be: ready  input  1  downstream can accept one word this cycle.
REQ-009 Port SHALL be: data_out  output  DATA_WIDTH  granted word, registered.
REQ-010 Port SHALL be: valid_out  output  1  data_out qualifier, registered.
REQ-011 Port SHALL be: lane_out  output  2  source lane of data_out, registered.
REQ-012 Port SHALL be: full0..full3  output  1 each  lane FIFO holds FIFO_DEPTH entries.
REQ-013 Port SHALL be: idle  output  1  all FIFOs empty and valid_out low.
REQ-014 Port SHALL be: error  output  1  sticky overflow flag.

Function
REQ-015 Each lane SHALL have an independent FIFO with write pointer, read pointer and occupancy count; pointers wrap modulo FIFO_DEPTH.
REQ-016 A write SHALL occur on a rising edge when valid_inN=1 and either countN<FIFO_DEPTH or lane N is popped on the same edge.
REQ-017 When valid_inN=1, countN=FIFO_DEPTH and lane N is not popped, the word SHALL be dropped, error set to 1, and the FIFO left unchanged.
REQ-018 Arbitration SHALL be round-robin: when ready=1, the granted lane is the first non-empty lane searching from rr_ptr upward, modulo 4.
REQ-019 On a grant, the edge SHALL pop the lane, load data_out and lane_out, set valid_out=1, and set rr_ptr to granted lane+1 mod 4.
REQ-020 With ready=0 or all FIFOs empty, the next edge SHALL set valid_out=0, hold data_out and lane_out, and leave rr_ptr unchanged.
REQ-021 Latency: a word written at edge k SHALL be presentable on data_out at edge k+1 at the earliest; an empty FIFO SHALL NOT bypass.
REQ-022 A simultaneous write and pop on one lane SHALL leave countN unchanged.
REQ-023 fullN and idle SHALL be decoded combinationally from registered state.

Reset
REQ-024 While reset_L=0, the block SHALL asynchronously clear all counts and pointers, set rr_ptr=0, clear data_out, lane_out, valid_out and error, and drive fullN=0 and idle=1.
REQ-025 Reset asserted mid-transfer SHALL discard all stored words; no partial word SHALL appear after release.
REQ-026 The first grant after reset release SHALL search from lane 0.

Configuration
REQ-027 With macro ALMOST_FULL_EN defined, the block SHALL add outputs almost_full0..almost_full3 (1 bit each), high when countN>=FIFO_DEPTH-1, for upstream flow-control pause.
REQ-028 Without ALMOST_FULL_EN, the block SHALL have no almost_full ports, and all other behaviour SHALL be identical.

Verification
REQ-029 Scenario: after reset, all four lanes carry 0x11/0x22/0x33/0x44 for 1 cycle with ready=1 -> data_out 0x11,0x22,0x33,0x44 on 4 consecutive edges, lane_out 0,1,2,3, then idle=1.
REQ-030 Scenario: lanes 0 and 2 carry one word each per cycle for 3 cycles with ready=1 -> output alternates lane 0/lane 2; the lane-2 FIFO grows to 2 entries while lane 0 drains, and no words are dropped.
REQ-031 Scenario: ready=0 while lane 1 receives 5 words 0xA0..0xA4 -> full1=1 after the 4th word, 0xA4 is dropped, error=1, and after ready=1 the output is 0xA0..0xA3 only.
REQ-032 Scenario: lane 3 full, with a simultaneous write of 0x55 and a grant of lane 3 -> countN stays at 4, and 0x55 appears later in FIFO order.
REQ-033 Scenario: reset_L pulsed low mid-stream with 2 words queued -> outputs cleared immediately, and nothing is emitted after release until new input arrives.
REQ-034 Scenario: with ALMOST_FULL_EN defined, 3 words are written to lane 0 with ready=0 -> almost_full0=1 and full0=0.

Source files
------------

// File: rtl/arbitro_fifos.sv
// -----------------------------------------------------------------------------
// arbitro_fifos
//   Four-lane ingress buffer with a round-robin output arbiter. Every lane owns
//   a small FIFO. Each cycle with ready high, one word is granted from the first
//   non-empty lane, searching upward from the round-robin pointer. The granted
//   word is presented on registered outputs. A word that arrives at a full lane
//   that is not being drained is dropped, and this sets a sticky error flag.
//
// Parameters
//   DATA_WIDTH  width of lane and output data (default 8)
//   FIFO_DEPTH  entries per lane FIFO, power of two, >= 2 (default 4)
//
// Ports
//   clk                       rising-edge clock
//   reset_L                   asynchronous active-low reset
//   data_in0..3 / valid_in0..3  lane words and their qualifiers
//   ready                     downstream accepts one word this cycle
//   data_out / valid_out / lane_out  granted word, qualifier, source lane (registered)
//   full0..3                  lane FIFO holds FIFO_DEPTH entries
//   idle                      every FIFO empty and valid_out low
//   error                     sticky overflow flag
//
// Optional feature
//   ALMOST_FULL_EN  adds almost_full0..3, high when a lane holds >= FIFO_DEPTH-1
//                   entries, so upstream can pause before words are dropped.
// -----------------------------------------------------------------------------
module arbitro_fifos #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [DATA_WIDTH-1:0] data_in3,
    input  logic                  valid_in0,
    input  logic                  valid_in1,
    input  logic                  valid_in2,
    input  logic                  valid_in3,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [1:0]            lane_out,
    output logic                  full0,
    output logic                  full1,
    output logic                  full2,
    output logic                  full3,
    output logic                  idle,
    output logic                  error
`ifdef ALMOST_FULL_EN
    ,
    output logic                  almost_full0,
    output logic                  almost_full1,
    output logic                  almost_full2,
    output logic                  almost_full3
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] w_data_in [4];
    logic [3:0]            w_valid_in;

    logic [DATA_WIDTH-1:0] r_mem   [4][FIFO_DEPTH];
    logic [PW-1:0]         r_wptr  [4];
    logic [PW-1:0]         r_rptr  [4];
    logic [CW-1:0]         r_count [4];
    logic [1:0]            r_rr_ptr;

    logic                  w_grant_valid;
    logic [1:0]            w_grant_lane;
    logic [1:0]            w_idx;
    logic [3:0]            w_pop;
    logic [3:0]            w_push;
    logic [3:0]            w_overflow;

    assign w_data_in[0] = data_in0;
    assign w_data_in[1] = data_in1;
    assign w_data_in[2] = data_in2;
    assign w_data_in[3] = data_in3;
    assign w_valid_in   = {valid_in3, valid_in2, valid_in1, valid_in0};

    // Round-robin search. Scanning from the farthest offset down to offset 0
    // leaves the nearest non-empty lane as the final winner. Only registered
    // counts are used, so a word written this cycle can never be granted in the
    // same cycle.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_lane  = r_rr_ptr;
        w_idx         = r_rr_ptr;
        if (ready) begin
            for (int i = 3; i >= 0; i--) begin
                w_idx = r_rr_ptr + 2'(i);
                if (r_count[w_idx] != '0) begin
                    w_grant_valid = 1'b1;
                    w_grant_lane  = w_idx;
                end
            end
        end
    end

    // A full lane can still accept a word when it is drained on the same edge.
    always_comb begin
        w_pop      = '0;
        w_push     = '0;
        w_overflow = '0;
        for (int l = 0; l < 4; l++) begin
            w_pop[l]      = w_grant_valid && (w_grant_lane == 2'(l));
            w_push[l]     = w_valid_in[l] && ((r_count[l] != DEPTH_C) || w_pop[l]);
            w_overflow[l] = w_valid_in[l] && (r_count[l] == DEPTH_C) && !w_pop[l];
        end
    end

    // Storage has no reset. Stale contents are unreachable once the counts clear.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (w_push[l]) begin
                r_mem[l][r_wptr[l]] <= w_data_in[l];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int l = 0; l < 4; l++) begin
                r_wptr[l]  <= '0;
                r_rptr[l]  <= '0;
                r_count[l] <= '0;
            end
            r_rr_ptr  <= 2'd0;
            data_out  <= '0;
            lane_out  <= 2'd0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (w_push[l]) begin
                    r_wptr[l] <= r_wptr[l] + PW'(1);
                end
                if (w_pop[l]) begin
                    r_rptr[l] <= r_rptr[l] + PW'(1);
                end
                case ({w_push[l], w_pop[l]})
                    2'b10:   r_count[l] <= r_count[l] + CW'(1);
                    2'b01:   r_count[l] <= r_count[l] - CW'(1);
                    default: r_count[l] <= r_count[l];
                endcase
            end
            valid_out <= w_grant_valid;
            if (w_grant_valid) begin
                data_out <= r_mem[w_grant_lane][r_rptr[w_grant_lane]];
                lane_out <= w_grant_lane;
                r_rr_ptr <= w_grant_lane + 2'd1;
            end
            if (|w_overflow) begin
                error <= 1'b1;
            end
        end
    end

    assign full0 = (r_count[0] == DEPTH_C);
    assign full1 = (r_count[1] == DEPTH_C);
    assign full2 = (r_count[2] == DEPTH_C);
    assign full3 = (r_count[3] == DEPTH_C);
    assign idle  = (r_count[0] == '0) && (r_count[1] == '0) &&
                   (r_count[2] == '0) && (r_count[3] == '0) && !valid_out;

`ifdef ALMOST_FULL_EN
    localparam logic [CW-1:0] ALMOST_C = CW'(FIFO_DEPTH - 1);
    assign almost_full0 = (r_count[0] >= ALMOST_C);
    assign almost_full1 = (r_count[1] >= ALMOST_C);
    assign almost_full2 = (r_count[2] >= ALMOST_C);
    assign almost_full3 = (r_count[3] >= ALMOST_C);
`endif

endmodule

// File: tb/tb_arbitro_fifos.sv
// -----------------------------------------------------------------------------
// tb_arbitro_fifos
//   Directed bench for arbitro_fifos. A queue-based reference model is updated
//   on every clock edge. A single compare process checks every DUT output
//   against this model on each falling edge. The directed scenarios also add
//   literal expectations, worked out by hand, that pin the model itself.
// -----------------------------------------------------------------------------
module tb_arbitro_fifos;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset_L;
    logic [DW-1:0] dataIn [4];
    logic [3:0]    validIn;
    logic          ready;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [1:0]    lane_out;
    logic          full0, full1, full2, full3;
    logic          idle;
    logic          error;
`ifdef ALMOST_FULL_EN
    logic          af0, af1, af2, af3;
`endif

    int nChecks = 0;
    int nPassed = 0;
    logic cmpEn = 1'b0;

    arbitro_fifos #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in0  (dataIn[0]),
        .data_in1  (dataIn[1]),
        .data_in2  (dataIn[2]),
        .data_in3  (dataIn[3]),
        .valid_in0 (validIn[0]),
        .valid_in1 (validIn[1]),
        .valid_in2 (validIn[2]),
        .valid_in3 (validIn[3]),
        .ready     (ready),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_out  (lane_out),
        .full0     (full0),
        .full1     (full1),
        .full2     (full2),
        .full3     (full3),
        .idle      (idle),
        .error     (error)
`ifdef ALMOST_FULL_EN
        ,
        .almost_full0 (af0),
        .almost_full1 (af1),
        .almost_full2 (af2),
        .almost_full3 (af3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per lane. On each edge the arbiter first takes
    // at most one word, then each lane tries to enqueue. Because the pop comes
    // first, a full lane that is drained on the same edge has room again.
    typedef logic [DW-1:0] byteQ_t [$];
    byteQ_t        mQ [4];
    int            mRr;
    int            mGrant;
    logic          mValid;
    logic [DW-1:0] mData;
    logic [1:0]    mLane;
    logic          mErr;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int l = 0; l < 4; l++) mQ[l].delete();
            mRr    = 0;
            mValid = 1'b0;
            mData  = '0;
            mLane  = 2'd0;
            mErr   = 1'b0;
        end else begin
            mGrant = -1;
            if (ready) begin
                for (int k = 0; k < 4; k++) begin
                    if (mGrant < 0 && mQ[(mRr + k) % 4].size() > 0) mGrant = (mRr + k) % 4;
                end
            end
            if (mGrant >= 0) begin
                mData  = mQ[mGrant].pop_front();
                mLane  = 2'(mGrant);
                mValid = 1'b1;
                mRr    = (mGrant + 1) % 4;
            end else begin
                mValid = 1'b0;
            end
            for (int l = 0; l < 4; l++) begin
                if (validIn[l]) begin
                    if (mQ[l].size() < DEPTH) mQ[l].push_back(dataIn[l]);
                    else mErr = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the model on each falling edge, halfway
    // between active edges.
    always @(negedge clk) begin
        if (cmpEn && reset_L) begin
            checkOutput("cmp.valid_out", 32'(valid_out), 32'(mValid));
            checkOutput("cmp.data_out",  32'(data_out),  32'(mData));
            checkOutput("cmp.lane_out",  32'(lane_out),  32'(mLane));
            checkOutput("cmp.full0", 32'(full0), 32'(mQ[0].size() == DEPTH));
            checkOutput("cmp.full1", 32'(full1), 32'(mQ[1].size() == DEPTH));
            checkOutput("cmp.full2", 32'(full2), 32'(mQ[2].size() == DEPTH));
            checkOutput("cmp.full3", 32'(full3), 32'(mQ[3].size() == DEPTH));
            checkOutput("cmp.idle",  32'(idle),
                        32'(mQ[0].size() == 0 && mQ[1].size() == 0 &&
                            mQ[2].size() == 0 && mQ[3].size() == 0 && !mValid));
            checkOutput("cmp.error", 32'(error), 32'(mErr));
        end
    end

    // Drive one cycle of inputs from a falling edge, then return at the next
    // falling edge, once the rising edge has used those inputs.
    task automatic applyStimulus(input logic [3:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                 input logic [DW-1:0] d2, input logic [DW-1:0] d3, input logic rdy);
        validIn   = v;
        dataIn[0] = d0;
        dataIn[1] = d1;
        dataIn[2] = d2;
        dataIn[3] = d3;
        ready     = rdy;
        @(negedge clk);
    endtask

    logic [DW-1:0] expData [8];
    logic [1:0]    expLane [8];

    initial begin
        reset_L = 1'b0;
        validIn = '0;
        ready   = 1'b0;
        for (int l = 0; l < 4; l++) dataIn[l] = '0;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst.valid_out", 32'(valid_out), 32'h0);
        checkOutput("rst.data_out",  32'(data_out),  32'h0);
        checkOutput("rst.lane_out",  32'(lane_out),  32'h0);
        checkOutput("rst.idle",      32'(idle),      32'h1);
        checkOutput("rst.full",      32'({full3, full2, full1, full0}), 32'h0);
        checkOutput("rst.error",     32'(error),     32'h0);
        reset_L = 1'b1;
        cmpEn   = 1'b1;

        // All four lanes loaded at once, drained in lane order
        applyStimulus(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        checkOutput("s1.no_bypass", 32'(valid_out), 32'h0);
        expData[0] = 8'h11; expData[1] = 8'h22; expData[2] = 8'h33; expData[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
            checkOutput("s1.valid", 32'(valid_out), 32'h1);
            checkOutput("s1.data",  32'(data_out),  32'(expData[i]));
            checkOutput("s1.lane",  32'(lane_out),  32'(i));
        end
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        checkOutput("s1.idle",  32'(idle),      32'h1);
        checkOutput("s1.hold",  32'(data_out),  32'h44);

        // Lanes 0 and 2 streaming together alternate on the output
        applyStimulus(4'b0101, 8'h01, 8'h00, 8'h21, 8'h00, 1'b1);
        applyStimulus(4'b0101, 8'h02, 8'h00, 8'h22, 8'h00, 1'b1);
        applyStimulus(4'b0101, 8'h03, 8'h00, 8'h23, 8'h00, 1'b1);
        checkOutput("s2.first_l2_data", 32'(data_out), 32'h21);
        checkOutput("s2.first_l2_lane", 32'(lane_out), 32'h2);
        expData[0] = 8'h02; expLane[0] = 2'd0;
        expData[1] = 8'h22; expLane[1] = 2'd2;
        expData[2] = 8'h03; expLane[2] = 2'd0;
        expData[3] = 8'h23; expLane[3] = 2'd2;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
            checkOutput("s2.data", 32'(data_out), 32'(expData[i]));
            checkOutput("s2.lane", 32'(lane_out), 32'(expLane[i]));
        end
        checkOutput("s2.no_drop", 32'(error), 32'h0);

        // Lane 1 overflows while downstream is stalled
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0010, 8'h00, 8'hA0 + 8'(i), 8'h00, 8'h00, 1'b0);
            if (i == 3) begin
                checkOutput("s3.full1_at4", 32'(full1), 32'h1);
                checkOutput("s3.err_at4",   32'(error), 32'h0);
            end
        end
        checkOutput("s3.err_set", 32'(error), 32'h1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
            checkOutput("s3.data", 32'(data_out), 32'(8'hA0 + 8'(i)));
            checkOutput("s3.lane", 32'(lane_out), 32'h1);
        end
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        checkOutput("s3.drained", 32'(valid_out), 32'h0);

        // Clear the sticky error, then write and pop a full lane 3 on the same edge
        @(posedge clk);
        #2 reset_L = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
        checkOutput("s4.err_cleared", 32'(error), 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b1000, 8'h00, 8'h00, 8'h00, 8'h60 + 8'(i), 1'b0);
        end
        checkOutput("s4.full3", 32'(full3), 32'h1);
        applyStimulus(4'b1000, 8'h00, 8'h00, 8'h00, 8'h55, 1'b1);
        checkOutput("s4.pop_data",  32'(data_out), 32'h60);
        checkOutput("s4.still_full", 32'(full3),   32'h1);
        checkOutput("s4.no_err",    32'(error),    32'h0);
        expData[0] = 8'h61; expData[1] = 8'h62; expData[2] = 8'h63; expData[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
            checkOutput("s4.data", 32'(data_out), 32'(expData[i]));
        end

        // Reset mid-stream with two words still queued on lane 0
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, 8'h70 + 8'(i), 8'h00, 8'h00, 8'h00, 1'b0);
        end
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        checkOutput("s5.pre_data", 32'(data_out), 32'h70);
        #2 reset_L = 1'b0;
        #1;
        checkOutput("s5.async_valid", 32'(valid_out), 32'h0);
        checkOutput("s5.async_data",  32'(data_out),  32'h0);
        checkOutput("s5.async_idle",  32'(idle),      32'h1);
        @(negedge clk);
        reset_L = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
            checkOutput("s5.silent", 32'(valid_out), 32'h0);
        end
        applyStimulus(4'b0101, 8'h80, 8'h00, 8'h82, 8'h00, 1'b1);
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        checkOutput("s5.first_lane", 32'(lane_out), 32'h0);
        checkOutput("s5.first_data", 32'(data_out), 32'h80);
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        checkOutput("s5.second_lane", 32'(lane_out), 32'h2);
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

`ifdef ALMOST_FULL_EN
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, 8'h90 + 8'(i), 8'h00, 8'h00, 8'h00, 1'b0);
        end
        checkOutput("s6.almost_full0", 32'(af0),   32'h1);
        checkOutput("s6.full0",        32'(full0), 32'h0);
        checkOutput("s6.almost_full1", 32'(af1),   32'h0);
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
`endif

        cmpEn = 1'b0;
        $display("[TB] %0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
